// File: rtl/bram_stream_reader.sv
// bram_stream_reader: reads a contiguous block of 32-bit words from the capture
// BRAM and streams it out as one AXI4-Stream burst terminated by TLAST.
module bram_stream_reader #(
    parameter int unsigned BRAM_DEPTH = 16384,
    parameter int unsigned ADDR_INCR  = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [31:0] length,
    output logic [31:0] addr_bram,
    output logic        memen,
    output logic [3:0]  web,
    input  logic [31:0] data_from_bram,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        busy,
    output logic        done,
    output logic [31:0] beats_sent
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] LAST_ADDR = 32'(BRAM_DEPTH - ADDR_INCR);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0]      length_reg;
    logic [31:0]      rd_count;
    logic             inflight;
    logic [31:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] fifo_count_next;
    logic [31:0]      next_addr;
    logic             push;
    logic             pop;
    logic             accept;
    logic             last_hs;
    logic             issue_next;

    // Stream side is a direct view of the FIFO head; tlast marks the final beat.
    assign push          = inflight;
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign accept        = (state == S_IDLE) && start;
    assign last_hs       = pop && m_axis_tlast;
    assign m_axis_tvalid = (fifo_count != '0);
    assign m_axis_tdata  = m_axis_tvalid ? fifo_mem[rd_ptr] : '0;
    assign m_axis_tlast  = m_axis_tvalid && (beats_sent == length_reg - 32'd1);
    assign web           = '0;
    assign next_addr     = (addr_bram == LAST_ADDR) ? '0 : addr_bram + 32'(ADDR_INCR);

    // Occupancy the FIFO will have next cycle.
    always_comb begin
        fifo_count_next = fifo_count;
        if (push && !pop) begin
            fifo_count_next = fifo_count + CNT_W'(1);
        end else if (!push && pop) begin
            fifo_count_next = fifo_count - CNT_W'(1);
        end
    end

    // Next state, plus the read decision for next cycle: the credit check uses the
    // occupancy and in-flight read that will be seen in that cycle.
    always_comb begin
        state_next = state;
        issue_next = 1'b0;
        unique case (state)
            S_IDLE:  if (start) state_next = (length == '0) ? S_DONE : S_RUN;
            S_RUN:   if (memen && (rd_count == 32'd1)) state_next = S_DRAIN;
            S_DRAIN: if (last_hs) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if ((state_next == S_RUN) &&
            ((32'(fifo_count_next) + 32'(memen)) < 32'(FIFO_DEPTH))) begin
            issue_next = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Read issue, transfer bookkeeping and status outputs.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            addr_bram  <= '0;
            memen      <= 1'b0;
            inflight   <= 1'b0;
            length_reg <= '0;
            rd_count   <= '0;
            beats_sent <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            memen    <= issue_next;
            inflight <= memen;
            busy     <= (state_next != S_IDLE);
            done     <= (state_next == S_DONE);
            if (accept) begin
                addr_bram  <= base_addr;
                rd_count   <= length;
                length_reg <= length;
                beats_sent <= '0;
            end else begin
                if (memen) begin
                    addr_bram <= next_addr;
                    rd_count  <= rd_count - 32'd1;
                end
                if (pop) begin
                    beats_sent <= beats_sent + 32'd1;
                end
            end
        end
    end

    // FIFO pointers and occupancy; in-flight data is dropped by reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            fifo_count <= fifo_count_next;
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
        end
    end

    // FIFO storage: capture BRAM data the cycle after each read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= data_from_bram;
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: BRAM model, randomized transfers, and a
// transaction-level reference checked every cycle.
module tb_bram_stream_reader;
    localparam int unsigned WORDS = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [31:0] length = '0;
    logic [31:0] addr_bram;
    logic        memen;
    logic [3:0]  web;
    logic [31:0] data_from_bram = '0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
    logic        busy;
    logic        done;
    logic [31:0] beats_sent;

    logic [31:0] bram [WORDS];
    int checks = 0;
    int failures = 0;
    int test_id = 0;

    always #5 clk = ~clk;

    bram_stream_reader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .base_addr      (base_addr),
        .length         (length),
        .addr_bram      (addr_bram),
        .memen          (memen),
        .web            (web),
        .data_from_bram (data_from_bram),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .busy           (busy),
        .done           (done),
        .beats_sent     (beats_sent)
    );

    // BRAM port model: one-cycle read latency.
    always @(posedge clk) begin
        if (memen) data_from_bram <= bram[addr_bram[13:2]];
    end

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a transfer is (base, len); issued/popped counters give the
    // expected addresses, FIFO visibility, data order, tlast, busy and done.
    initial begin : compare
        bit          rst_chk = 1'b1;
        bit          m_busy = 1'b0;
        bit          m_done = 1'b0;
        int unsigned m_len = 0;
        int unsigned m_base = 0;
        int unsigned m_issued = 0;
        int unsigned m_issued_d = 0;
        int unsigned m_popped = 0;
        int          m_tid = 0;
        int          rel = 1000000;
        bit          stall = 1'b0;
        logic [31:0] st_data = '0;
        logic        st_last = 1'b0;
        bit          wd = 1'b0;
        bit          tv_exp;
        bit          busy_n;
        bit          done_n;
        logic [31:0] wrap_lit [4];
        wrap_lit = '{32'd16376, 32'd16380, 32'd0, 32'd4};
        forever begin
            @(negedge clk);
            rel++;
            if (rst_chk) begin
                chk(addr_bram == 32'd0, "rst_addr", addr_bram, 32'd0);
                chk(m_axis_tdata == 32'd0, "rst_tdata", m_axis_tdata, 32'd0);
                chk(beats_sent == 32'd0, "rst_beats", beats_sent, 32'd0);
                chk({memen, web, m_axis_tvalid, m_axis_tlast, busy, done} == 9'd0, "rst_ctrl",
                    32'({memen, web, m_axis_tvalid, m_axis_tlast, busy, done}), 32'd0);
            end else begin
                tv_exp = (m_issued_d > m_popped);
                chk(busy == m_busy, "busy", 32'(busy), 32'(m_busy));
                chk(done == m_done, "done", 32'(done), 32'(m_done));
                chk(beats_sent == m_popped, "beats_sent", beats_sent, m_popped);
                chk(m_axis_tvalid == tv_exp, "tvalid", 32'(m_axis_tvalid), 32'(tv_exp));
                chk(web == 4'd0, "web", 32'(web), 32'd0);
                if (tv_exp) begin
                    chk(m_axis_tdata == bram[((m_base >> 2) + m_popped) % WORDS], "tdata",
                        m_axis_tdata, bram[((m_base >> 2) + m_popped) % WORDS]);
                    chk(m_axis_tlast == (m_popped == m_len - 1), "tlast",
                        32'(m_axis_tlast), 32'(m_popped == m_len - 1));
                end else begin
                    chk(m_axis_tlast == 1'b0, "tlast_idle", 32'(m_axis_tlast), 32'd0);
                end
                if (stall) begin
                    chk(m_axis_tdata == st_data && m_axis_tlast == st_last && m_axis_tvalid,
                        "stall_hold", m_axis_tdata, st_data);
                end
                if (memen) begin
                    chk(m_busy && !m_done && (m_issued < m_len), "memen_legal", m_issued, m_len);
                    chk(addr_bram == 32'((m_base + 4 * m_issued) % 16384), "addr",
                        addr_bram, 32'((m_base + 4 * m_issued) % 16384));
                    chk((m_issued - m_popped) < 4, "credit", m_issued - m_popped, 32'd4);
                end
                case (m_tid)
                    1: begin
                        if (rel == 3) chk(m_axis_tvalid && m_axis_tdata == 32'hA000_0000, "basic_first", m_axis_tdata, 32'hA000_0000);
                        if (rel == 9) chk(!m_axis_tlast, "basic_no_early_last", 32'(m_axis_tlast), 32'd0);
                        if (rel == 10) chk(m_axis_tlast && m_axis_tdata == 32'hA000_0007, "basic_last", m_axis_tdata, 32'hA000_0007);
                        if (rel == 11) chk(done, "basic_done", 32'(done), 32'd1);
                        if (rel == 12) chk(beats_sent == 32'd8 && !busy, "basic_beats", beats_sent, 32'd8);
                    end
                    3: begin
                        if (rel >= 1 && rel <= 4) chk(memen && addr_bram == wrap_lit[rel-1], "wrap_addr", addr_bram, wrap_lit[rel-1]);
                        if (rel == 7) chk(done, "wrap_done", 32'(done), 32'd1);
                    end
                    4: begin
                        if (rel == 1) chk(done && busy, "zero_done", 32'({busy, done}), 32'd3);
                        if (rel == 2) chk(!busy && !done, "zero_idle", 32'({busy, done}), 32'd0);
                    end
                    5: begin
                        if (rel == 11) chk(done, "ignored_done", 32'(done), 32'd1);
                        if (rel == 12) chk(beats_sent == 32'd8, "ignored_beats", beats_sent, 32'd8);
                    end
                    6: begin
                        if (rel == 3) chk(m_axis_tvalid && !m_axis_tlast, "post_rst_first", 32'({m_axis_tvalid, m_axis_tlast}), 32'd2);
                        if (rel == 4) chk(m_axis_tvalid && m_axis_tlast, "post_rst_last", 32'({m_axis_tvalid, m_axis_tlast}), 32'd3);
                        if (rel == 5) chk(done, "post_rst_done", 32'(done), 32'd1);
                    end
                    default: ;
                endcase
                if (m_busy && !wd && rel > 400) begin
                    wd = 1'b1;
                    checks++;
                    failures++;
                    $display("FAIL watchdog transfer still busy after %0d cycles", rel);
                end
            end
            // Advance the reference by what happens at the coming clock edge.
            if (rst_n) begin
                rst_chk = 1'b1;
                m_busy = 1'b0; m_done = 1'b0; m_len = 0; m_base = 0;
                m_issued = 0; m_issued_d = 0; m_popped = 0; m_tid = 0;
                stall = 1'b0; rel = 1000000;
            end else begin
                rst_chk = 1'b0;
                tv_exp = (m_issued_d > m_popped);
                done_n = 1'b0;
                m_issued_d = m_issued;
                if (memen) m_issued++;
                if (tv_exp && m_axis_tready) begin
                    m_popped++;
                    if (m_popped == m_len) done_n = 1'b1;
                end
                stall = tv_exp && !m_axis_tready;
                st_data = m_axis_tdata;
                st_last = m_axis_tlast;
                busy_n = m_busy && !m_done;
                if (!m_busy && start) begin
                    busy_n = 1'b1;
                    done_n = (length == 32'd0);
                    m_len = length; m_base = base_addr;
                    m_issued = 0; m_issued_d = 0; m_popped = 0;
                    m_tid = test_id; rel = 0; stall = 1'b0;
                end
                m_busy = busy_n;
                m_done = done_n;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input int mode);
        m_axis_tready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle(input int mode);
        int n = 0;
        while (busy && n < 500) begin
            set_ready(mode);
            cyc();
            n++;
        end
        m_axis_tready = 1'b1;
        repeat (2) cyc();
    endtask

    task automatic run(input int tid, input logic [31:0] b, input logic [31:0] n, input int mode);
        test_id = tid; base_addr = b; length = n; start = 1'b1;
        set_ready(mode);
        cyc();
        start = 1'b0;
        wait_idle(mode);
    endtask

    initial begin : stim
        for (int i = 0; i < int'(WORDS); i++) begin
            bram[i] = (i < 64) ? 32'hA000_0000 + 32'(i) : $urandom;
        end
        rst_n = 1'b1;
        repeat (3) cyc();
        rst_n = 1'b0;
        repeat (2) cyc();

        run(1, 32'd0, 32'd8, 0);
        run(2, 32'($urandom_range(0, 4095)) << 2, 32'd16, 1);
        run(3, 32'd16376, 32'd4, 0);
        run(4, 32'd40, 32'd0, 0);

        // Second start while busy must be ignored.
        test_id = 5; base_addr = 32'd0; length = 32'd8; start = 1'b1; m_axis_tready = 1'b1;
        cyc();
        start = 1'b0;
        repeat (3) cyc();
        base_addr = 32'd400; length = 32'd5; start = 1'b1;
        cyc();
        start = 1'b0;
        wait_idle(0);

        // Reset after three beats of a ten-word transfer.
        test_id = 0; base_addr = 32'($urandom_range(0, 4095)) << 2; length = 32'd10;
        start = 1'b1; m_axis_tready = 1'b1;
        cyc();
        start = 1'b0;
        repeat (4) cyc();
        rst_n = 1'b1;
        cyc();
        rst_n = 1'b0;
        repeat (2) cyc();
        run(6, 32'($urandom_range(0, 4095)) << 2, 32'd2, 0);

        for (int k = 0; k < 6; k++) begin
            run(7, 32'($urandom_range(0, 4095)) << 2, 32'($urandom_range(1, 24)), 1);
        end
        run(7, 32'd16368, 32'd9, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Readback stage downstream of the BRAM data generator. Reads a contiguous block of 32-bit words from the capture BRAM through the second BRAM port and emits them as an AXI4-Stream master burst with TLAST, so a DMA can move the buffer to DDR. Software starts a transfer through the custom AXI slave registers with base address and length. The block reports busy/done and a beat count.

## Interface
- `BRAM_DEPTH`, 16384: BRAM size in bytes. Byte address space is `0 .. BRAM_DEPTH-1`.
- `ADDR_INCR`, 4: byte-address step per word.
- `FIFO_DEPTH`, 4: output buffer entries. Minimum 4.

- `clk`  in  1: single clock for all logic.
- `rst_n`  in  1: synchronous reset, **active-high** despite the suffix. Sampled on the `clk` rising edge.
- `start`  in  1: one-cycle request. Honoured only in IDLE.
- `base_addr`  in  32: first byte address. Must be a multiple of `ADDR_INCR` and below `BRAM_DEPTH`. Captured on an accepted `start`.
- `length`  in  32: number of words to read. Captured on an accepted `start`.
- `addr_bram`  out  32: BRAM byte address.
- `memen`  out  1: BRAM enable. High only in a cycle that issues a read.
- `web`  out  4: BRAM byte write enables. Constant 0.
- `data_from_bram`  in  32: BRAM read data. Valid exactly 1 cycle after the issuing `memen` cycle.
- `m_axis_tdata`  out  32: stream data.
- `m_axis_tvalid`  out  1: stream valid.
- `m_axis_tready`  in  1: stream ready.
- `m_axis_tlast`  out  1: high on the final beat.
- `busy`  out  1: high in any state other than IDLE.
- `done`  out  1: one-cycle pulse when the transfer completes.
- `beats_sent`  out  32: handshakes completed in the current or most recent transfer.

## Operation
- **FSM states:** IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `start` with `length != 0`.
  - IDLE → DONE on `start` with `length == 0`. No reads are issued and no beats are sent.
  - RUN → DRAIN in the cycle the last read is issued.
  - DRAIN → DONE in the cycle the last beat handshakes.
  - DONE → IDLE unconditionally after 1 cycle. `done` is high in DONE only.
- **Start handling:** `start` outside IDLE is ignored and captures nothing. On an accepted `start`:
  - `beats_sent` clears to 0.
  - The read address register loads `base_addr`.
  - The read counter loads `length`.
- **Read issue:** in RUN, a read is issued (`memen`=1) in any cycle where `fifo_count + inflight < FIFO_DEPTH`.
  - `inflight` is 1 if a read was issued in the previous cycle, else 0.
  - After each issue, the address advances by `ADDR_INCR` and the counter decrements.
- **Wrap:** if the current address is `BRAM_DEPTH - ADDR_INCR`, the next address is 0. Arithmetic is 32-bit unsigned.
- **Capture:** `data_from_bram` is written into the FIFO in the cycle after an issue, unconditionally. The credit rule guarantees the FIFO is never full at that point.
- **Stream:** `m_axis_tvalid` = FIFO not empty; `m_axis_tdata` = FIFO head.
  - A pop occurs on `tvalid && tready`.
  - `tlast` = `(beats_sent == length_reg - 1) && tvalid`.
  - `tdata`, `tlast` and `tvalid` are held stable while `tvalid && !tready`.
- **Simultaneous push and pop:** `fifo_count` is unchanged.
- **Reset mid-transfer:** FSM returns to IDLE. FIFO and in-flight flag are cleared. Outstanding reads are discarded with no further beats. `rst_n` has priority over `start`.

## Timing
- **Reset values:**
  - Data outputs: `addr_bram`=0, `memen`=0, `web`=0, `m_axis_tdata`=0.
  - Control outputs: `m_axis_tvalid`=0, `m_axis_tlast`=0, `busy`=0, `done`=0, `beats_sent`=0.
- **Start latency:** with `start` in cycle 0, the sequence is:
  - cycle 1: RUN, first read issued (`memen`=1, `addr_bram`=`base_addr`).
  - cycle 2: data captured.
  - cycle 3: `m_axis_tvalid`=1 with word 0.
- **Throughput:** with `m_axis_tready` held high, one beat per cycle with no bubbles. An N-word transfer puts its last beat in cycle N+2 and pulses `done` in cycle N+3.
- **Zero length:** `start` with `length == 0` pulses `done` in cycle 1 and returns `busy` low in cycle 2.
- **Registered outputs:** `addr_bram` and `memen` are registered. `busy` is high from cycle 1 through the DONE cycle inclusive.

## Test plan
- **Basic burst:** BRAM preloaded with word i = 0xA000_0000+i. `base_addr`=0, `length`=8, `tready`=1 → tdata 0xA000_0000..0xA000_0007 in cycles 3..10; `tlast` only in cycle 10; `done` in cycle 11; `beats_sent`=8.
- **Backpressure:** `length`=16 with `tready` toggled pseudo-randomly → 16 beats, in order, none duplicated; tdata/tlast stable while stalled; `memen` never issues while `fifo_count + inflight` = 4.
- **Wrap-around:** `base_addr`=16376, `length`=4 → `addr_bram` sequence 16376, 16380, 0, 4; data from those locations in that order.
- **Zero length and ignored start:** `length`=0 → `done` in cycle 1, no `tvalid`. A second `start` pulsed mid-burst (`length`=8) → ignored, exactly 8 beats.
- **Reset mid-transfer:** `rst_n` asserted after 3 beats of a `length`=10 transfer → next cycle all outputs at reset values. A new `start` with `length`=2 → exactly 2 beats with `tlast` on the second.
